// File: rtl/imem_fetch_responder_if.sv
// Fetch request/response bundle between the IF stage and the instruction
// memory responder. Both directions use valid/ready: a beat transfers on a
// rising clock edge where valid and ready are both high; the initiator holds
// valid and its payload stable until that edge.
interface imem_fetch_responder_if #(
    parameter int WORD_LEN = 16
) ();
    logic                req_valid;
    logic                req_ready;
    logic [WORD_LEN-1:0] req_addr;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [WORD_LEN-1:0] rsp_instr;
    logic [WORD_LEN-1:0] rsp_addr;
    logic                rsp_err;

    // IF stage side: issues requests, consumes responses
    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
    );

    // Memory side: accepts requests, produces responses
    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
    );
endinterface

// File: rtl/imem_fetch_responder.sv
// Multi-cycle instruction memory responder. One request in flight at a time:
// accept, wait a fixed LATENCY, present the word until the fetch side takes it.
// Flush aborts whatever is pending; the program array is loaded via ld_*.
module imem_fetch_responder #(
    parameter int WORD_LEN = 16,
    parameter int DEPTH    = 64,
    parameter int LATENCY  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    imem_fetch_responder_if.slave    bus,
    input  logic                     flush,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_index,
    input  logic [WORD_LEN-1:0]      ld_data,
    output logic                     busy,
    output logic [1:0]               fsm_state
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt;
    logic [WORD_LEN-1:0] addr_q;
    logic [WORD_LEN-1:0] rsp_instr_q;
    logic [WORD_LEN-1:0] rsp_addr_q;
    logic                rsp_err_q;
    logic                req_ready;
    logic                accept;

    logic [WORD_LEN-1:0] mem [DEPTH];

    // Lookup of the latched address: PC advances by 4, so the word index drops
    // the two byte-offset bits; anything misaligned or past the array is an error.
    logic [WORD_LEN-1:0] idx_full;
    logic                addr_err;
    assign idx_full = addr_q >> 2;
    assign addr_err = (addr_q[1:0] != 2'b00) || (idx_full >= WORD_LEN'(DEPTH));

    // Request acceptance and next state; flush overrides every transition
    always_comb begin
        req_ready = 1'b0;
        state_n   = state;
        case (state)
            IDLE:    req_ready = ~flush;
            RESP:    req_ready = bus.rsp_ready & ~flush;
            default: req_ready = 1'b0;
        endcase
        accept = bus.req_valid & req_ready;
        case (state)
            IDLE:    if (accept) state_n = WAIT;
            WAIT:    if (cnt == '0) state_n = RESP;
            RESP:    if (bus.rsp_ready) state_n = accept ? WAIT : IDLE;
            default: state_n = IDLE;
        endcase
        if (flush) state_n = IDLE;
    end

    // State, latency counter, latched address and registered response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            addr_q      <= '0;
            rsp_instr_q <= '0;
            rsp_addr_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                addr_q <= bus.req_addr;
                cnt    <= CNT_W'(LATENCY - 1);
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            // Array read happens on the same edge as any load write, so a
            // colliding write is seen by the next read, not this one.
            if (state == WAIT && cnt == '0 && !flush) begin
                rsp_instr_q <= addr_err ? '0 : mem[idx_full[IDX_W-1:0]];
                rsp_addr_q  <= addr_q;
                rsp_err_q   <= addr_err;
            end
        end
    end

    // Program load port, honoured regardless of the fetch state
    always_ff @(posedge clk) begin
        if (ld_en) mem[ld_index] <= ld_data;
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_instr = rsp_instr_q;
    assign bus.rsp_addr  = rsp_addr_q;
    assign bus.rsp_err   = rsp_err_q;
    assign busy          = (state != IDLE);
    assign fsm_state     = state;
endmodule
